// File: rtl/ysyx_041514_pipe_ctrl_pkg.sv
// Shared configuration for the pipeline hazard/redirect controller:
// control-bus bit indices, bus width, XLEN and FSM state encodings.
package ysyx_041514_pipe_ctrl_pkg;

    localparam int ysyx_041514_XLEN         = 64;
    localparam int ysyx_041514_CTRLBUS_W    = 6;

    localparam int ysyx_041514_CTRLBUS_PC     = 0;
    localparam int ysyx_041514_CTRLBUS_IF_ID  = 1;
    localparam int ysyx_041514_CTRLBUS_ID_EX  = 2;
    localparam int ysyx_041514_CTRLBUS_EX_MEM = 3;
    localparam int ysyx_041514_CTRLBUS_MEM_WB = 4;

    typedef enum logic {
        ST_IDLE       = 1'b0,
        ST_WAIT_FETCH = 1'b1
    } ctrl_state_e;

    // Contiguous mask with bits lo..hi set on the control bus.
    function automatic logic [ysyx_041514_CTRLBUS_W-1:0] bus_range(input int lo, input int hi);
        logic [ysyx_041514_CTRLBUS_W-1:0] m;
        m = '0;
        for (int i = 0; i < ysyx_041514_CTRLBUS_W; i++) begin
            m[i] = (i >= lo) && (i <= hi);
        end
        return m;
    endfunction

endpackage

// File: rtl/ysyx_041514_pipe_ctrl_hazard_prio.sv
// Fixed-priority merge of busy/hazard requests into per-stage stall and
// flush vectors. Purely combinational.
module ysyx_041514_hazard_prio
    import ysyx_041514_pipe_ctrl_pkg::*;
(
    input  logic       trap_i,
    input  logic       mem_busy_i,
    input  logic       ex_busy_i,
    input  logic       redirect_i,
    input  logic       load_use_i,
    input  logic       if_busy_i,
    output logic [5:0] stall_o,
    output logic [5:0] flush_o,
    output logic       trap_win_o,
    output logic       redirect_win_o
);

    // Highest-priority request alone decides both vectors.
    always_comb begin
        stall_o        = 6'b000000;
        flush_o        = 6'b000000;
        trap_win_o     = 1'b0;
        redirect_win_o = 1'b0;
        if (trap_i) begin
            stall_o    = bus_range(ysyx_041514_CTRLBUS_PC, ysyx_041514_CTRLBUS_PC);
            flush_o    = bus_range(ysyx_041514_CTRLBUS_IF_ID, ysyx_041514_CTRLBUS_MEM_WB);
            trap_win_o = 1'b1;
        end else if (mem_busy_i) begin
            stall_o = bus_range(ysyx_041514_CTRLBUS_PC, ysyx_041514_CTRLBUS_EX_MEM);
            flush_o = bus_range(ysyx_041514_CTRLBUS_MEM_WB, ysyx_041514_CTRLBUS_MEM_WB);
        end else if (ex_busy_i) begin
            stall_o = bus_range(ysyx_041514_CTRLBUS_PC, ysyx_041514_CTRLBUS_ID_EX);
            flush_o = bus_range(ysyx_041514_CTRLBUS_EX_MEM, ysyx_041514_CTRLBUS_EX_MEM);
        end else if (redirect_i) begin
            flush_o        = bus_range(ysyx_041514_CTRLBUS_IF_ID, ysyx_041514_CTRLBUS_ID_EX);
            redirect_win_o = 1'b1;
        end else if (load_use_i) begin
            stall_o = bus_range(ysyx_041514_CTRLBUS_PC, ysyx_041514_CTRLBUS_IF_ID);
            flush_o = bus_range(ysyx_041514_CTRLBUS_ID_EX, ysyx_041514_CTRLBUS_ID_EX);
        end else if (if_busy_i) begin
            stall_o = bus_range(ysyx_041514_CTRLBUS_PC, ysyx_041514_CTRLBUS_PC);
            flush_o = bus_range(ysyx_041514_CTRLBUS_IF_ID, ysyx_041514_CTRLBUS_IF_ID);
        end else begin
            stall_o = 6'b000000;
            flush_o = 6'b000000;
        end
    end

endmodule

// File: rtl/ysyx_041514_pipe_ctrl.sv
// Central hazard/redirect controller: stall/flush vectors, PC redirect port
// and optional perf counters (enabled by YSYX_041514_PERF_CNT_EN).
module ysyx_041514_pipe_ctrl
    import ysyx_041514_pipe_ctrl_pkg::*;
#(
    parameter int XLEN = ysyx_041514_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_busy_i,
    input  logic            load_use_i,
    input  logic            ex_busy_i,
    input  logic            mem_busy_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    output logic [5:0]      stall_valid_o,
    output logic [5:0]      flush_valid_o,
    output logic            pc_redirect_valid_o,
    output logic [XLEN-1:0] pc_redirect_o,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
);

    ctrl_state_e     state_q, state_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;

    logic            in_wait_s;
    logic [5:0]      prio_stall_s, prio_flush_s;
    logic            trap_win_s, redirect_win_s;
    logic [5:0]      stall_s, flush_s;
    logic            redir_valid_s;
    logic [XLEN-1:0] redir_pc_s;

    assign in_wait_s = (state_q == ST_WAIT_FETCH);

    // Younger instructions are already flushed while waiting, so a new EX redirect is ignored.
    ysyx_041514_hazard_prio u_prio (
        .trap_i         (trap_valid_i),
        .mem_busy_i     (mem_busy_i),
        .ex_busy_i      (ex_busy_i),
        .redirect_i     (redirect_valid_i & ~in_wait_s),
        .load_use_i     (load_use_i),
        .if_busy_i      (if_busy_i),
        .stall_o        (prio_stall_s),
        .flush_o        (prio_flush_s),
        .trap_win_o     (trap_win_s),
        .redirect_win_o (redirect_win_s)
    );

    // Redirect FSM next state, pending target and final vectors.
    always_comb begin
        state_d       = state_q;
        pend_pc_d     = pend_pc_q;
        stall_s       = prio_stall_s;
        flush_s       = prio_flush_s;
        redir_valid_s = 1'b0;
        redir_pc_s    = '0;
        case (state_q)
            ST_IDLE: begin
                if (trap_win_s || redirect_win_s) begin
                    if (if_busy_i) begin
                        state_d   = ST_WAIT_FETCH;
                        pend_pc_d = trap_win_s ? trap_pc_i : redirect_pc_i;
                    end else begin
                        redir_valid_s = 1'b1;
                        redir_pc_s    = trap_win_s ? trap_pc_i : redirect_pc_i;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_FETCH: begin
                // A held register keeps its bubble; stall wins so no bit is both held and flushed.
                stall_s = prio_stall_s | 6'b000001;
                flush_s = (prio_flush_s | 6'b000010) & ~stall_s;
                if (!if_busy_i) begin
                    redir_valid_s = 1'b1;
                    redir_pc_s    = trap_valid_i ? trap_pc_i : pend_pc_q;
                    state_d       = ST_IDLE;
                end else if (trap_valid_i) begin
                    pend_pc_d = trap_pc_i;
                end else begin
                    pend_pc_d = pend_pc_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign stall_valid_o       = rst ? stall_s       : 6'b000000;
    assign flush_valid_o       = rst ? flush_s       : 6'b000000;
    assign pc_redirect_valid_o = rst ? redir_valid_s : 1'b0;
    assign pc_redirect_o       = rst ? redir_pc_s    : '0;

    // FSM state and pending redirect target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
        end
    end

`ifdef YSYX_041514_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    // Free-running, wrapping stall/flush cycle counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_s[ysyx_041514_CTRLBUS_PC] ? stall_cnt_q + 32'd1 : stall_cnt_q;
            flush_cnt_q <= (|flush_s) ? flush_cnt_q + 32'd1 : flush_cnt_q;
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    assign perf_stall_cnt_o = 32'd0;
    assign perf_flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_ysyx_041514_pipe_ctrl.sv
// Self-checking bench for ysyx_041514_pipe_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the redirect controller.
module tb_ysyx_041514_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_busy, load_use, ex_busy, mem_busy, redir_v, trap_v;
    logic [63:0] redir_pc, trap_pc;
    logic [5:0]  stall_o, flush_o;
    logic        pcr_v;
    logic [63:0] pcr;
    logic [31:0] pstall, pflush;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: is a redirect waiting for a fetch, and to where.
    logic        m_pending;
    logic [63:0] m_target;
    logic [31:0] m_scnt, m_fcnt;
    logic [5:0]  e_st, e_fl;
    logic        e_rv;
    logic [63:0] e_pc;

    ysyx_041514_pipe_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_busy_i           (if_busy),
        .load_use_i          (load_use),
        .ex_busy_i           (ex_busy),
        .mem_busy_i          (mem_busy),
        .redirect_valid_i    (redir_v),
        .redirect_pc_i       (redir_pc),
        .trap_valid_i        (trap_v),
        .trap_pc_i           (trap_pc),
        .stall_valid_o       (stall_o),
        .flush_valid_o       (flush_o),
        .pc_redirect_valid_o (pcr_v),
        .pc_redirect_o       (pcr),
        .perf_stall_cnt_o    (pstall),
        .perf_flush_cnt_o    (pflush)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setin(input logic ifb, input logic lu, input logic exb, input logic memb,
                         input logic rv, input logic [63:0] rpc, input logic tv, input logic [63:0] tpc);
        if_busy = ifb; load_use = lu; ex_busy = exb; mem_busy = memb;
        redir_v = rv; redir_pc = rpc; trap_v = tv; trap_pc = tpc;
    endtask

    task automatic model_reset();
        m_pending = 1'b0;
        m_target  = 64'd0;
        m_scnt    = 32'd0;
        m_fcnt    = 32'd0;
    endtask

    // Expected outputs from the priority table and the pending-redirect rule.
    task automatic model_eval();
        int   depth;
        logic wins_tgt;
        logic [63:0] tgt;
        logic [5:0] fmask;
        depth = 0; fmask = 6'd0; wins_tgt = 1'b0; tgt = 64'd0;
        if (trap_v) begin
            depth = 1; fmask = 6'b011110; wins_tgt = 1'b1; tgt = trap_pc;
        end else if (mem_busy) begin
            depth = 4; fmask = 6'b010000;
        end else if (ex_busy) begin
            depth = 3; fmask = 6'b001000;
        end else if (redir_v && !m_pending) begin
            depth = 0; fmask = 6'b000110; wins_tgt = 1'b1; tgt = redir_pc;
        end else if (load_use) begin
            depth = 2; fmask = 6'b000100;
        end else if (if_busy) begin
            depth = 1; fmask = 6'b000010;
        end
        e_st = 6'((32'd1 << depth) - 32'd1);
        e_fl = fmask;
        e_rv = 1'b0;
        e_pc = 64'd0;
        if (m_pending) begin
            e_st = e_st | 6'b000001;
            e_fl = (e_fl | 6'b000010) & ~e_st;
            if (!if_busy) begin
                e_rv = 1'b1;
                e_pc = trap_v ? trap_pc : m_target;
            end
        end else if (wins_tgt && !if_busy) begin
            e_rv = 1'b1;
            e_pc = tgt;
        end
        if (!rst) begin
            e_st = 6'd0; e_fl = 6'd0; e_rv = 1'b0; e_pc = 64'd0;
        end
    endtask

    // Mid-cycle comparison of every DUT output against the model.
    task automatic eval();
        #4;
        if (!rst) model_reset();
        model_eval();
        chk("stall_vec", {58'd0, stall_o}, {58'd0, e_st});
        chk("flush_vec", {58'd0, flush_o}, {58'd0, e_fl});
        chk("redir_valid", {63'd0, pcr_v}, {63'd0, e_rv});
        if (e_rv) chk("redir_pc", pcr, e_pc);
`ifdef YSYX_041514_PERF_CNT_EN
        chk("perf_stall", {32'd0, pstall}, {32'd0, m_scnt});
        chk("perf_flush", {32'd0, pflush}, {32'd0, m_fcnt});
`else
        chk("perf_stall", {32'd0, pstall}, 64'd0);
        chk("perf_flush", {32'd0, pflush}, 64'd0);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (e_st[0]) m_scnt = m_scnt + 32'd1;
            if (|e_fl)   m_fcnt = m_fcnt + 32'd1;
            if (m_pending) begin
                if (!if_busy) m_pending = 1'b0;
                else if (trap_v) m_target = trap_pc;
            end else if (!if_busy && !(trap_v || mem_busy || ex_busy)) begin
                m_pending = 1'b0;
            end else if (if_busy && (trap_v || (redir_v && !mem_busy && !ex_busy))) begin
                m_pending = 1'b1;
                m_target  = trap_v ? trap_pc : redir_pc;
            end
        end
        #1;
    endtask

    task automatic idle_in();
        setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
    endtask

    initial begin
        idle_in();
        model_reset();
        #1;
        chk("reset_stall", {58'd0, stall_o}, 64'd0);
        chk("reset_redir", {63'd0, pcr_v}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // load-use alone
        setin(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        eval();
        chk("lu_stall", {58'd0, stall_o}, 64'h03);
        chk("lu_flush", {58'd0, flush_o}, 64'h04);
        chk("lu_noredir", {63'd0, pcr_v}, 64'd0);
        tick();

        // mem_busy beats load-use for 3 cycles
        for (int i = 0; i < 3; i++) begin
            setin(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 64'd0);
            eval();
            chk("mem_stall", {58'd0, stall_o}, 64'h0F);
            chk("mem_flush", {58'd0, flush_o}, 64'h10);
            tick();
        end

        // redirect with fetch idle: same-cycle PC update
        setin(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0040, 1'b0, 64'd0);
        eval();
        chk("br_flush", {58'd0, flush_o}, 64'h06);
        chk("br_valid", {63'd0, pcr_v}, 64'd1);
        chk("br_pc", pcr, 64'h8000_0040);
        tick();

        // redirect while fetch busy: held until fetch returns
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
        eval();
        chk("brw_novalid", {63'd0, pcr_v}, 64'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
            eval();
            chk("wait_flush1", {63'd0, flush_o[1]}, 64'd1);
            chk("wait_novalid", {63'd0, pcr_v}, 64'd0);
            tick();
        end
        idle_in();
        eval();
        chk("ret_valid", {63'd0, pcr_v}, 64'd1);
        chk("ret_pc", pcr, 64'h8000_0100);
        tick();
        eval();
        chk("idle_flush", {58'd0, flush_o}, 64'd0);
        chk("idle_novalid", {63'd0, pcr_v}, 64'd0);
        tick();

        // trap during wait overrides the pending target
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0100, 1'b0, 64'd0);
        eval(); tick();
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b1, 64'h8000_0004);
        eval();
        chk("trapw_flush", {58'd0, flush_o}, 64'h1E);
        chk("trapw_stall", {58'd0, stall_o}, 64'h01);
        tick();
        idle_in();
        eval();
        chk("trapw_pc", pcr, 64'h8000_0004);
        tick();

        // reset while waiting drops the pending redirect
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0200, 1'b0, 64'd0);
        eval(); tick();
        setin(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0, 64'd0);
        rst = 1'b0;
        eval();
        chk("rst_stall", {58'd0, stall_o}, 64'd0);
        chk("rst_flush", {58'd0, flush_o}, 64'd0);
        chk("rst_valid", {63'd0, pcr_v}, 64'd0);
        tick();
        rst = 1'b1;
        idle_in();
        eval();
        chk("post_rst_novalid", {63'd0, pcr_v}, 64'd0);
        chk("post_rst_scnt", {32'd0, pstall}, 64'd0);
        chk("post_rst_fcnt", {32'd0, pflush}, 64'd0);
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            setin($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 12,
                  $urandom_range(0, 99) < 20, {$urandom, $urandom},
                  $urandom_range(0, 99) < 6,  {$urandom, $urandom});
            rst = ($urandom_range(0, 199) != 0);
            eval();
            tick();
        end
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ysyx_041514_pipe_ctrl.md
# ysyx_041514_pipe_ctrl

Central hazard and redirect controller for the five-stage core. It produces the per-stage `stall_valid` and `flush_valid` vectors consumed by the PC register and every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB). It merges busy and hazard requests by fixed priority and owns the single PC-redirect port. A small state machine holds a branch or trap redirect until any in-flight instruction fetch has returned, so a stale fetch never enters the pipeline.

## Interface
- `XLEN`, 64, PC/target width.
- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_busy_i`  in  1  fetch outstanding; IF result not yet valid.
- `load_use_i`  in  1  ID detects load-use dependency on ID/EX.
- `ex_busy_i`  in  1  multi-cycle EX op (mul/div) not finished.
- `mem_busy_i`  in  1  LSU transaction not finished.
- `redirect_valid_i` / `redirect_pc_i`  in  1 / XLEN  branch/jump mispredict from EX.
- `trap_valid_i` / `trap_pc_i`  in  1 / XLEN  exception/interrupt/xRET from commit, with target vector.
- `stall_valid_o`  out  6  bit k: hold register k.
- `flush_valid_o`  out  6  bit k: load NOP/zero into register k.
- `pc_redirect_valid_o` / `pc_redirect_o`  out  1 / XLEN  load PC with target.
- `perf_stall_cnt_o`, `perf_flush_cnt_o`  out  32 each  performance counters.

## Operation
- Bit map: 0 PC, 1 IF_ID, 2 ID_EX, 3 EX_MEM, 4 MEM_WB, 5 reserved (always 0).
- Priority, highest first; only the winner drives the vectors:
  - trap: flush 1..4, stall 0, redirect to `trap_pc_i`.
  - mem_busy: stall 0..3, flush 4.
  - ex_busy: stall 0..2, flush 3.
  - redirect: flush 1..2, redirect to `redirect_pc_i`.
  - load_use: stall 0..1, flush 2.
  - if_busy: stall 0, flush 1.
  - none: all zero.
- Invariants: stall bits are contiguous from bit 0. No bit is both stalled and flushed.
- FSM states IDLE and WAIT_FETCH. The pending target register `pend_pc` is XLEN bits.
- IDLE, trap or redirect wins, `if_busy_i`=0: `pc_redirect_valid_o`=1 the same cycle; stay IDLE.
- IDLE, trap or redirect wins, `if_busy_i`=1: latch target into `pend_pc`; go WAIT_FETCH. Apply the flushes above; no redirect output yet.
- WAIT_FETCH:
  - Force flush bit 1 and stall bit 0 every cycle, OR'd with any lower-priority vector.
  - A new trap overwrites `pend_pc`; trap flushes apply. A new redirect is ignored, since younger instructions are already flushed.
  - When `if_busy_i`=0: drive `pc_redirect_valid_o`=1 with `pend_pc` that cycle, then return to IDLE. If a trap is present that same cycle, its `trap_pc_i` is used.
- `mem_busy_i` in WAIT_FETCH: its stall bits apply, except bit 0, which stays stalled. The redirect output is still issued when the fetch returns; the PC update has priority over the PC stall.

## Timing
- Vector and redirect outputs are combinational from inputs and state. Zero-cycle latency.
- State, `pend_pc` and counters update on the rising `clk`.
- Reset (`rst`=0, async): state IDLE, `pend_pc`=0, counters 0. All outputs are 0 while reset is held.
- Reset mid-WAIT_FETCH drops the pending redirect.
- Simultaneous trap and redirect: trap wins; the redirect is dropped.

## Configuration
- `YSYX_041514_PERF_CNT_EN` defined:
  - `perf_stall_cnt_o` increments each cycle `stall_valid_o[0]`=1.
  - `perf_flush_cnt_o` increments each cycle any `flush_valid_o` bit is 1.
  - Both wrap from 2^32-1 to 0.
- Undefined: no counter registers; both outputs tied to 0.

## Structure
- The shared config header holds:
  - `ysyx_041514_CTRLBUS_*` bit indices (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
  - The 6-bit control bus width.
  - `ysyx_041514_XLEN`.
  - FSM state encodings.
- One sub-module `ysyx_041514_hazard_prio`: purely combinational priority encoder producing the vectors. The FSM and counters stay in the top module.

## Test plan
- `load_use_i`=1 alone for one cycle -> stall=6'b000011, flush=6'b000100; no redirect.
- `mem_busy_i`=1 with `load_use_i`=1 for 3 cycles -> stall=6'b001111, flush=6'b010000 each cycle.
- `redirect_valid_i`=1, `redirect_pc_i`=0x8000_0040, `if_busy_i`=0:
  - Same cycle: flush=6'b000110, `pc_redirect_valid_o`=1, `pc_redirect_o`=0x8000_0040.
- Redirect to 0x8000_0100 while `if_busy_i`=1 for 4 more cycles:
  - Flush bit 1 set each cycle.
  - Redirect output asserted only in the cycle `if_busy_i` falls, with 0x8000_0100.
  - FSM back in IDLE next cycle.
- Trap to 0x8000_0004 during WAIT_FETCH with pending 0x8000_0100:
  - flush=6'b011110.
  - Redirect issued on fetch return with 0x8000_0004.
- `rst` pulled low in WAIT_FETCH:
  - Outputs 0 immediately.
  - After release, no redirect is issued.
  - With `YSYX_041514_PERF_CNT_EN`, counters read 0.
